// File: rtl/branch_flag_unit.sv
// NZCV flag register, conditional-jump resolver with a circular link stack,
// and a one-entry registered result stage with valid/ready handshake.
module branch_flag_unit #(
  parameter int          REG_WIDTH  = 16,
  parameter logic [3:0]  JMP_OPC    = 4'b1100,
  parameter logic [7:0]  CV_MASK    = 8'b1101_1110,
  parameter int          LINK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] ins,
  input  logic [REG_WIDTH-1:0] immext,
  input  logic [REG_WIDTH-1:0] pc,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_v,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 br_taken,
  output logic [REG_WIDTH-1:0] br_target,
  output logic [3:0]           flags,
  output logic                 stk_ovf,
  output logic                 stk_unf
);

  localparam int PTR_W = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
  localparam int CNT_W = $clog2(LINK_DEPTH + 1);

  // Handshake: a transfer into the unit happens when in_valid && in_ready;
  // a result leaves when out_valid && out_ready. The held result may be
  // replaced in the same cycle it is taken, giving one result per cycle.
  logic [3:0]           flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;
  logic                 br_taken_q, br_taken_d;
  logic [REG_WIDTH-1:0] br_target_q, br_target_d;
  logic [REG_WIDTH-1:0] stk_mem_q [LINK_DEPTH];
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 accept;
  logic                 is_alu;
  logic                 is_jmp;
  logic [3:0]           cond;
  logic                 cond_true;
  logic                 push_en;
  logic [PTR_W-1:0]     top_idx;
  logic [PTR_W-1:0]     nxt_idx;
  logic                 unused_ins;

  assign unused_ins = ^ins;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_alu   = !ins[15];
  assign is_jmp   = (ins[15:12] == JMP_OPC);
  assign cond     = ins[11:8];

  // ptr_q is the next free slot; when full it also names the oldest entry.
  assign top_idx = (ptr_q == '0) ? PTR_W'(LINK_DEPTH - 1) : ptr_q - PTR_W'(1);
  assign nxt_idx = (ptr_q == PTR_W'(LINK_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = flags_q[2];
      4'h3: cond_true = !flags_q[2];
      4'h4: cond_true = flags_q[1];
      4'h5: cond_true = !flags_q[1];
      4'h6: cond_true = flags_q[3];
      4'h7: cond_true = !flags_q[3];
      4'h8: cond_true = (flags_q[3] == flags_q[0]);
      4'h9: cond_true = (flags_q[3] != flags_q[0]);
      4'hA: cond_true = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'hB: cond_true = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'hC: cond_true = flags_q[1] && !flags_q[2];
      4'hD: cond_true = !flags_q[1] || flags_q[2];
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    flags_d     = flags_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_en     = 1'b0;
    if (accept && is_alu) begin
      flags_d[3:2] = {alu_n, alu_z};
      if (CV_MASK[ins[14:12]]) flags_d[1:0] = {alu_c, alu_v};
    end
    if (accept && is_jmp) begin
      br_taken_d  = cond_true;
      br_target_d = pc + immext;
      if (cond == 4'hE) begin
        push_en = 1'b1;
        ptr_d   = nxt_idx;
        if (cnt_q == CNT_W'(LINK_DEPTH)) ovf_d = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end else if (cond == 4'hF) begin
        if (cnt_q == '0) begin
          br_target_d = '0;
          unf_d       = 1'b1;
        end else begin
          br_target_d = stk_mem_q[top_idx];
          ptr_d       = top_idx;
          cnt_d       = cnt_q - CNT_W'(1);
        end
      end
    end
    if (flush) out_valid_d = 1'b0;
    else if (accept && is_jmp) out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINK_DEPTH; i++) stk_mem_q[i] <= '0;
    end else if (push_en) begin
      stk_mem_q[ptr_q] <= pc + REG_WIDTH'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign flags     = flags_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule
